// File: rtl/add_pipe_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
package add_pipe_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 16;
  localparam int unsigned DEFAULT_STAGES = 4;

  // Returns 0 when the width does not split evenly so the top can refuse to elaborate.
  function automatic int unsigned chunk_of(int unsigned width, int unsigned stages);
    if (stages == 0 || (width % stages) != 0) return 0;
    return width / stages;
  endfunction

endpackage

// File: rtl/add_pipe_chunk.sv
// Combinational CHUNK-bit ripple of full-adder cells.
module add_pipe_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             c_out,
  output logic             c_msb_in
);

  logic carry;

  always_comb begin
    sum      = '0;
    carry    = cin;
    c_msb_in = cin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      c_msb_in = carry;
      sum[i]   = a[i] ^ b[i] ^ carry;
      carry    = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    c_out = carry;
  end

endmodule

// File: rtl/add_pipe_n.sv
// Pipelined WIDTH-bit adder/subtractor, STAGES chunks, valid/ready with global stall.
module add_pipe_n
  import add_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned CHUNK = chunk_of(WIDTH, STAGES);

  if (CHUNK == 0) begin : g_bad_split
    $error("add_pipe_n: WIDTH must be a non-zero multiple of STAGES");
  end

  logic             advance;
  logic             xfer;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;
  assign xfer     = in_valid & advance;
  assign b_eff    = sub ? ~b : b;
  assign c_eff    = sub ? ~cin : cin;

  // Per-stage register outputs and combinational chunk results.
  logic             v_o  [STAGES];
  logic [WIDTH-1:0] a_o  [STAGES];
  logic [WIDTH-1:0] b_o  [STAGES];
  logic [WIDTH-1:0] s_o  [STAGES];
  logic             c_o  [STAGES];
  logic             v_in [STAGES];
  logic             cc_w [STAGES];
  logic             cm_w [STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic [WIDTH-1:0] a_in, b_in, s_in, s_nx;
    logic             c_in;
    logic [CHUNK-1:0] cs;
    logic             v_q, c_q;
    logic [WIDTH-1:0] a_q, b_q, s_q;

    if (i == 0) begin : g_head
      assign v_in[i] = xfer;
      assign a_in    = a;
      assign b_in    = b_eff;
      assign s_in    = '0;
      assign c_in    = c_eff;
    end else begin : g_body
      assign v_in[i] = v_o[i-1];
      assign a_in    = a_o[i-1];
      assign b_in    = b_o[i-1];
      assign s_in    = s_o[i-1];
      assign c_in    = c_o[i-1];
    end

    add_pipe_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a        (a_in[i*CHUNK +: CHUNK]),
      .b        (b_in[i*CHUNK +: CHUNK]),
      .cin      (c_in),
      .sum      (cs),
      .c_out    (cc_w[i]),
      .c_msb_in (cm_w[i])
    );

    always_comb begin
      s_nx                   = s_in;
      s_nx[i*CHUNK +: CHUNK] = cs;
    end

    // Data only loads behind a valid token, so outputs keep the last result across bubbles.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (advance) begin
        v_q <= v_in[i];
        if (v_in[i]) begin
          a_q <= a_in;
          b_q <= b_in;
          s_q <= s_nx;
          c_q <= cc_w[i];
        end
      end
    end

    assign v_o[i] = v_q;
    assign a_o[i] = a_q;
    assign b_o[i] = b_q;
    assign s_o[i] = s_q;
    assign c_o[i] = c_q;
  end

  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (advance && v_in[STAGES-1]) begin
      ovf_q <= cc_w[STAGES-1] ^ cm_w[STAGES-1];
    end
  end

  assign out_valid = v_o[STAGES-1];
  assign sum       = s_o[STAGES-1];
  assign c_out     = c_o[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_pipe_n.sv
// Directed/random bench for add_pipe_n with a result scoreboard.
module tb_add_pipe_n;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  add_pipe_n #(.WIDTH(W), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  res_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pops   = 0;

  function automatic res_t model(input logic [W-1:0] ma, mb, input logic mc, ms);
    logic [W-1:0] be;
    logic         ce;
    logic [W:0]   full;
    res_t         r;
    be   = ms ? ~mb : mb;
    ce   = ms ? ~mc : mc;
    full = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, ce};
    r.s  = full[W-1:0];
    r.c  = full[W];
    r.o  = (ma[W-1] == be[W-1]) && (full[W-1] != ma[W-1]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Monitor: scoreboard push on transfer, pop/compare on result handshake, upstream hold check.
  logic         pend = 1'b0;
  logic [W-1:0] pa, pb;
  logic         pc, ps;

  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend)
        chk("hold_stable", {in_valid, a, b, cin, sub}, {1'b1, pa, pb, pc, ps});
      pend = in_valid && !in_ready;
      pa = a; pb = b; pc = cin; ps = sub;
      if (in_valid && in_ready)
        sb.push_back(model(a, b, cin, sub));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $error("FAIL unexpected_result: observed sum %0h with no result expected", sum);
        end else begin
          res_t e;
          e = sb.pop_front();
          chk("result", {sum, c_out, ovf}, e);
          n_pops++;
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] ta, tb, input logic tc, ts);
    logic acc;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) return;
    end
    chk("send_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (sb.size() == 0) return;
      @(posedge clk); #1;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int base;
    // Reset for two edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum",       64'(sum),       64'd0);
    chk("rst_c_out",     64'(c_out),     64'd0);
    chk("rst_ovf",       64'(ovf),       64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Latency: acceptance edge counted, result held while out_ready=0.
    out_ready = 1'b0;
    send(16'h00FF, 16'h0001, 1'b0, 1'b0);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lat_not_yet", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_sum", {sum, c_out, ovf}, {16'h0100, 1'b0, 1'b0});
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("lat_hold", {out_valid, sum}, {1'b1, 16'h0100});
    end
    @(posedge clk); #1;
    drain();

    // Carry/overflow and subtract corner vectors.
    base = n_pops;
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    send(16'h0005, 16'h0002, 1'b1, 1'b1);
    in_valid = 1'b0;
    drain();
    chk("corner_count", 64'(n_pops - base), 64'd5);

    // Back-to-back random stream.
    base = n_pops;
    for (int k = 0; k < 8; k++)
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    in_valid = 1'b0;
    drain();
    chk("stream_count", 64'(n_pops - base), 64'd8);

    // Fill with out_ready low, then hold the next operand against backpressure.
    base = n_pops;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    a = 16'h1234; b = 16'h4321; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_frozen", {out_valid, sum, c_out, ovf}, {1'b1, sb[0]});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(16'h1234, 16'h4321, 1'b1, 1'b0);
    in_valid = 1'b0;
    drain();
    chk("stall_count", 64'(n_pops - base), 64'd5);

    // Reset with three operations in flight.
    for (int k = 0; k < 3; k++)
      send(16'($urandom), 16'($urandom), 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    base = n_pops;
    send(16'hA5A5, 16'h5A5A, 1'b0, 1'b1);
    in_valid = 1'b0;
    drain();
    chk("post_reset_count", 64'(n_pops - base), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/add_pipe_n.md
Name: add_pipe_n

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor. It generalises the single-bit registered full adder to WIDTH bits, split into STAGES register-separated chunks.
- Adds a valid/ready handshake with backpressure, a subtract mode and a signed-overflow flag.
- Arithmetic leaf for datapaths that need a registered wide add at high clock rate.

Parameters:
- WIDTH, 16, operand/result width in bits.
- STAGES, 4, pipeline stages; each stage resolves CHUNK = WIDTH/STAGES bits.
- WIDTH % STAGES != 0 is an elaboration error.

Ports:
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands a, b, cin, sub are valid this cycle
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (borrow-in when sub=1)
- sub  in  1  0: a+b+cin; 1: a-b-cin
- out_valid  out  1  result fields valid
- out_ready  in  1  consumer takes the result this cycle
- sum  out  WIDTH  result
- c_out  out  1  carry out of MSB (sub mode: 1 = no borrow)
- ovf  out  1  two's-complement overflow

Behaviour:
- Reset: at a rising edge with rst=1, all stage valid bits, sum, c_out and ovf go to 0. in_ready=1 in the cycle after. rst overrides every other input.
- Operand conditioning at entry:
  - b_eff = sub ? ~b : b
  - c_eff = sub ? ~cin : cin
  - sub=1 therefore yields a + ~b + ~cin = a - b - cin.
- Stage i (0..STAGES-1):
  - Adds chunk i of a and b_eff plus the carry registered by stage i-1 (c_eff for stage 0).
  - Registers the chunk-i sum and carry.
  - Carries forward the untouched higher operand chunks and all lower result chunks.
- advance = ~out_valid | out_ready (global stall; bubbles are not collapsed).
- in_ready = advance, combinational. Transfer = in_valid & in_ready.
- On advance:
  - Each stage's valid bit loads its predecessor's valid; stage 0 loads the transfer.
  - A stage's data registers load only when its incoming valid is 1. When the incoming valid is 0 the data holds, so sum/c_out/ovf keep the last result.
- When advance=0, every register holds. out_valid, sum, c_out and ovf stay stable until out_ready=1.
- Latency: a transfer at edge k sets out_valid after edge k+STAGES-1, so the result takes STAGES edges counting the acceptance edge. STAGES=1 gives a single registered adder.
- Throughput: one result per cycle while out_ready=1. Results emerge in acceptance order, with none lost or duplicated.
- c_out = carry out of bit WIDTH-1.
- ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, captured in the final stage.
- Reset mid-operation: in-flight operations are discarded. out_valid stays 0 until a new transfer has travelled the full latency.
- in_valid=1 while in_ready=0: the operands are not taken. The upstream keeps them stable; this is checked by an assertion in the bench.

Decomposition:
- Shared package add_pipe_pkg holds:
  - default WIDTH/STAGES constants
  - a function computing CHUNK with the divisibility check
- Sub-module add_pipe_chunk: combinational CHUNK-bit ripple of full-adder cells.
  - Ports: a, b, cin, sum, c_out, c_msb_in (carry into its top bit, used for ovf).
  - The top level generates STAGES instances plus the stage registers.

Test Plan (WIDTH=16, STAGES=4):
- Reset: rst=1 for 2 edges -> out_valid=0, sum=0x0000, c_out=0, ovf=0, in_ready=1.
- a=0x00FF, b=0x0001, cin=0, sub=0, single transfer -> out_valid rises after the 4th edge (acceptance edge counted); sum=0x0100, c_out=0, ovf=0. out_valid stays 1 until out_ready=1.
- Full-width carry and overflow:
  - a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, c_out=1, ovf=0.
  - a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, c_out=0, ovf=1.
- Subtract, sub=1:
  - a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, c_out=0, ovf=0.
  - a=0x8000, b=0x0001, cin=0 -> sum=0x7FFF, c_out=1, ovf=1.
  - a=0x0005, b=0x0002, cin=1 -> sum=0x0002, c_out=1.
- Streaming and stall:
  - 8 back-to-back random transfers with out_ready=1 -> 8 consecutive results, in order, matching the model.
  - out_ready=0 with the pipeline full -> in_ready=0 and outputs frozen for 5 cycles.
  - Release -> the remaining results arrive, none dropped or repeated.
- Reset mid-flight: 3 transfers accepted, rst=1 at the next edge -> out_valid=0 for the following 4 cycles with in_valid=0; no stale result is ever presented.
